// File: rtl/sum_accumulator_if.sv
// Handshake bundle for sum_accumulator: run control,
// sample input stream and result output stream.
interface sum_accumulator_if #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic [8:0]       in_sum;
  logic             in_valid;
  logic             in_ready;
  logic             busy;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output start,
    output len,
    output in_sum,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  busy,
    input  out_acc,
    input  out_ovf,
    input  out_valid
  );

  modport slave (
    input  start,
    input  len,
    input  in_sum,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output busy,
    output out_acc,
    output out_ovf,
    output out_valid
  );
endinterface

// File: rtl/sum_accumulator.sv
// Saturating accumulator over a run of len 9-bit samples,
// with valid/ready on both the sample and result sides.
module sum_accumulator #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  sum_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [ACC_W:0]   sum;
  logic             last;

  // one spare bit catches the carry that signals saturation
  assign sum  = {1'b0, acc_q}
              + {{(ACC_W-8){1'b0}}, bus.in_sum};
  assign last = (cnt_q == len_q - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          len_d   = bus.len;
          state_d = (bus.len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          if (sum[ACC_W]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (last) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_acc   = acc_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench: 16-bit and 10-bit instances share stimulus;
// table vectors, reset sequences and random runs.
module tb_sum_accumulator;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] len;
  logic [8:0] in_sum;
  logic       in_valid;
  logic       out_ready;

  int checks;
  int errors;

  sum_accumulator_if #(.ACC_W(16), .CNT_W(4)) if16 ();
  sum_accumulator_if #(.ACC_W(10), .CNT_W(4)) if10 ();

  assign if16.start     = start;
  assign if16.len       = len;
  assign if16.in_sum    = in_sum;
  assign if16.in_valid  = in_valid;
  assign if16.out_ready = out_ready;
  assign if10.start     = start;
  assign if10.len       = len;
  assign if10.in_sum    = in_sum;
  assign if10.in_valid  = in_valid;
  assign if10.out_ready = out_ready;

  sum_accumulator #(.ACC_W(16), .CNT_W(4)) u16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16)
  );

  sum_accumulator #(.ACC_W(10), .CNT_W(4)) u10 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n;
    int s0, s1, s2, s3;
    int mode;
    int hold;
    int e16, o16;
    int e10, o10;
    int glitch;
  } vec_t;

  vec_t tbl[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void chk(string name,
                              logic [31:0] got,
                              logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d",
               name, got, exp);
    end
  endfunction

  task automatic chk_zero(string tag);
    chk({tag, "_rdy16"}, 32'(if16.in_ready), 0);
    chk({tag, "_busy16"}, 32'(if16.busy), 0);
    chk({tag, "_vld16"}, 32'(if16.out_valid), 0);
    chk({tag, "_acc16"}, 32'(if16.out_acc), 0);
    chk({tag, "_ovf16"}, 32'(if16.out_ovf), 0);
    chk({tag, "_busy10"}, 32'(if10.busy), 0);
    chk({tag, "_acc10"}, 32'(if10.out_acc), 0);
    chk({tag, "_ovf10"}, 32'(if10.out_ovf), 0);
  endtask

  task automatic chk_result(string tag,
                            int e16, int o16,
                            int e10, int o10);
    chk({tag, "_vld16"}, 32'(if16.out_valid), 1);
    chk({tag, "_vld10"}, 32'(if10.out_valid), 1);
    chk({tag, "_rdy16"}, 32'(if16.in_ready), 0);
    chk({tag, "_busy16"}, 32'(if16.busy), 1);
    chk({tag, "_acc16"}, 32'(if16.out_acc), e16);
    chk({tag, "_ovf16"}, 32'(if16.out_ovf), o16);
    chk({tag, "_acc10"}, 32'(if10.out_acc), e10);
    chk({tag, "_ovf10"}, 32'(if10.out_ovf), o10);
  endtask

  // mode 0: continuous, 1: 1,0,0 pattern, 2: random
  task automatic run(string tag, int n, int smp[16],
                     int mode, int hold,
                     int e16, int o16,
                     int e10, int o10, int glitch);
    int acc_n;
    int cyc;
    start = 1'b1;
    len   = 4'(n);
    step();
    start = 1'b0;
    if (n != 0) begin
      acc_n = 0;
      cyc   = 0;
      while (acc_n < n && cyc < 200) begin
        chk({tag, "_inrdy16"}, 32'(if16.in_ready), 1);
        chk({tag, "_inrdy10"}, 32'(if10.in_ready), 1);
        chk({tag, "_midvld"}, 32'(if16.out_valid), 0);
        case (mode)
          1:       in_valid = (cyc % 3 == 0);
          2:       in_valid = ($urandom_range(0, 3) != 0);
          default: in_valid = 1'b1;
        endcase
        in_sum = 9'(smp[acc_n]);
        if (glitch != 0) begin
          start = 1'($urandom_range(0, 1));
          len   = 4'($urandom_range(0, 15));
        end
        step();
        if (in_valid) acc_n++;
        cyc++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (acc_n < n) chk({tag, "_timeout"}, 32'(acc_n), n);
    end
    chk_result(tag, e16, o16, e10, o10);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (glitch != 0) begin
        start = 1'b1;
        len   = 4'($urandom_range(1, 15));
      end
      in_valid = 1'($urandom_range(0, 1));
      in_sum   = 9'($urandom_range(0, 511));
      step();
      chk_result({tag, "_hold"}, e16, o16, e10, o10);
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idlevld"}, 32'(if16.out_valid), 0);
    chk({tag, "_idlebusy"}, 32'(if16.busy), 0);
    chk({tag, "_idlerdy"}, 32'(if16.in_ready), 0);
    chk({tag, "_keep16"}, 32'(if16.out_acc), e16);
    chk({tag, "_keep10"}, 32'(if10.out_acc), e10);
  endtask

  initial begin
    int smp[16];
    int total;
    int n;
    checks    = 0;
    errors    = 0;
    start     = 1'b0;
    len       = '0;
    in_sum    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;

    tbl[0] = '{3, 255, 510, 1, 0, 0, 0,
               766, 0, 766, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 1,
               0, 0, 0, 0, 0};
    tbl[2] = '{3, 511, 511, 511, 0, 0, 0,
               1533, 0, 1023, 1, 0};
    tbl[3] = '{1, 5, 0, 0, 0, 0, 0,
               5, 0, 5, 0, 0};
    tbl[4] = '{2, 100, 200, 0, 0, 1, 4,
               300, 0, 300, 0, 0};
    tbl[5] = '{4, 511, 511, 1, 0, 0, 2,
               1023, 0, 1023, 0, 1};
    tbl[6] = '{4, 511, 511, 2, 0, 2, 1,
               1024, 0, 1023, 1, 1};

    #3 rst_n = 1'b0;
    #1 chk_zero("reset");
    step();
    step();
    chk_zero("inreset");
    rst_n = 1'b1;
    chk_zero("postreset");

    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 16; k++) smp[k] = 0;
      smp[0] = tbl[i].s0;
      smp[1] = tbl[i].s1;
      smp[2] = tbl[i].s2;
      smp[3] = tbl[i].s3;
      run($sformatf("vec%0d", i), tbl[i].n, smp,
          tbl[i].mode, tbl[i].hold,
          tbl[i].e16, tbl[i].o16,
          tbl[i].e10, tbl[i].o10, tbl[i].glitch);
    end

    // abort a run mid-way with an asynchronous reset
    start = 1'b1;
    len   = 4'd4;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    in_sum   = 9'd300;
    step();
    step();
    in_valid = 1'b0;
    chk("midrun_acc", 32'(if16.out_acc), 600);
    #2 rst_n = 1'b0;
    #1 chk_zero("async");
    step();
    chk_zero("async_hold");
    #2 rst_n = 1'b1;
    for (int k = 0; k < 16; k++) smp[k] = 0;
    smp[0] = 7;
    step();
    run("after_rst", 1, smp, 0, 0, 7, 0, 7, 0, 0);

    for (int r = 0; r < 25; r++) begin
      n     = $urandom_range(0, 15);
      total = 0;
      for (int k = 0; k < 16; k++) begin
        smp[k] = $urandom_range(0, 511);
        if (k < n) total += smp[k];
      end
      run($sformatf("rnd%0d", r), n, smp, 2,
          $urandom_range(0, 3),
          (total > 65535) ? 65535 : total,
          (total > 65535) ? 1 : 0,
          (total > 1023) ? 1023 : total,
          (total > 1023) ? 1 : 0,
          $urandom_range(0, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 16, accumulator and result width (must be >= 10).
REQ-002 SHALL have parameter CNT_W, default 4, width of the sample-count field.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin a new accumulation run (sampled in IDLE only).
REQ-006 SHALL have port len  input  CNT_W  number of samples in the run, sampled with start.
REQ-007 SHALL have port in_sum  input  9  unsigned 9-bit sum from the upstream 8-bit adder stage.
REQ-008 SHALL have port in_valid  input  1  in_sum is valid this cycle.
REQ-009 SHALL have port in_ready  output  1  block accepts in_sum this cycle.
REQ-010 SHALL have port busy  output  1  high in ACCUM and DONE.
REQ-011 SHALL have port out_acc  output  ACC_W  accumulated result.
REQ-012 SHALL have port out_ovf  output  1  saturation occurred during the run.
REQ-013 SHALL have port out_valid  output  1  out_acc/out_ovf valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the result.

Function
REQ-015 SHALL implement FSM with states IDLE, ACCUM, DONE; in_ready = (state==ACCUM), out_valid = (state==DONE), busy = (state!=IDLE), all driven from registered state.
REQ-016 In IDLE with start=1 and len!=0: SHALL clear acc and ovf, latch len, clear sample counter, go to ACCUM next cycle.
REQ-017 In IDLE with start=1 and len==0: SHALL clear acc and ovf and go directly to DONE (result 0, ovf 0).
REQ-018 start SHALL be ignored in ACCUM and DONE; len changes after the start cycle SHALL have no effect.
REQ-019 Input handshake: a sample is consumed only on a cycle with in_valid=1 and in_ready=1; in_valid without in_ready SHALL have no effect.
REQ-020 On each accepted sample: acc <= acc + zero-extend(in_sum) to ACC_W+1 bits; if the sum exceeds 2^ACC_W-1, acc SHALL saturate to 2^ACC_W-1 and ovf SHALL set (sticky until next start).
REQ-021 Sample counter SHALL increment per accepted sample; when the accepted sample is number len (counter == len-1), state SHALL move to DONE on that same edge.
REQ-022 Latency: out_valid SHALL assert the cycle immediately after the last accepted sample; in_ready deasserts on that same cycle.
REQ-023 In DONE: out_acc and out_ovf SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 On out_valid=1 and out_ready=1: SHALL return to IDLE next cycle; out_acc/out_ovf retain last value in IDLE until next start clears them.
REQ-025 Back-to-back: start asserted in the first IDLE cycle after the result handshake SHALL be honoured; minimum gap between runs is one IDLE cycle.
REQ-026 Gaps in in_valid during ACCUM SHALL stall the run indefinitely with no state change.
REQ-027 out_acc SHALL be the acc register directly (no combinational path from in_sum to out_acc).

Reset
REQ-028 rst_n=0 SHALL, asynchronously and at any time including mid-run, force state=IDLE, acc=0, ovf=0, counter=0, latched len=0.
REQ-029 During and after reset: in_ready=0, busy=0, out_valid=0, out_acc=0, out_ovf=0; any partial run is discarded.
REQ-030 First start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-031 start, len=3; samples 9'd255, 9'd510, 9'd1 with in_valid continuous -> out_valid one cycle after third accept, out_acc=766, out_ovf=0.
REQ-032 start, len=0 -> out_valid next cycle, out_acc=0, out_ovf=0, in_ready never asserted.
REQ-033 ACC_W=10, len=3, samples 511,511,511 -> out_acc=1023, out_ovf=1; next run len=1 sample 5 -> out_acc=5, out_ovf=0.
REQ-034 len=2, in_valid toggling 1,0,0,1 with out_ready=0 for 4 cycles in DONE -> out_acc = sum of the two accepted samples, held stable, IDLE one cycle after out_ready=1.
REQ-035 len=4, rst_n pulsed low after second accept -> all outputs 0 immediately, IDLE; new run len=1 sample 7 -> out_acc=7.
REQ-036 start pulsed during ACCUM and DONE with different len -> ignored, run completes with original len.
